// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV64 5-stage pipeline.
// Holds the canonical NOP encoding and the fetched-instruction record.
package riscv_pipe_pkg;

  localparam int unsigned XLEN = 64;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush, used for fetched entries and in-flight PCs.
// Pushing while full is accepted only when a pop happens in the same cycle.
module fetch_queue #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited imem requests,
// buffers in-order responses and drives the IF/ID register with stall/flush.
module if_fetch_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] fetch_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instruction
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   stale_q, stale_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;

  logic            req_fire, rsp_live, rsp_keep;
  logic            q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]   q_count;
  entry_t          q_head, rsp_entry;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   pcq_count;
  logic            pcq_full, pcq_empty;

  // Requests are only issued while every in-flight response has a guaranteed slot.
  assign imem_req_valid = reset && !redirect_valid &&
                          ((outstanding_q + q_count) < CW'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_live       = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep       = rsp_live && (stale_q == '0) && !redirect_valid;
  assign rsp_entry      = '{pc: rsp_pc, instr: imem_rsp_data};

  assign q_push = rsp_keep && (stall || !q_empty);
  assign q_pop  = !redirect_valid && !stall && !q_empty;

  fetch_queue #(.DEPTH(FQ_DEPTH), .WIDTH($bits(entry_t))) u_entry_q (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (q_push),
    .push_data_i (rsp_entry),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // Never flushed: stale responses still arrive and must pop their PC.
  fetch_queue #(.DEPTH(FQ_DEPTH), .WIDTH(XLEN)) u_inflight_q (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (1'b0),
    .push_i      (req_fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (rsp_live),
    .head_o      (rsp_pc),
    .count_o     (pcq_count),
    .full_o      (pcq_full),
    .empty_o     (pcq_empty)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    stale_d       = stale_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_live);

    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc;
      stale_d       = outstanding_q - CW'(rsp_live);
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_live && (stale_q != '0)) stale_d = stale_q - CW'(1);
      if (!stall) begin
        if (!q_empty) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = q_head.pc;
          if_id_instr_d = q_head.instr;
        end else if (rsp_keep) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = rsp_entry.pc;
          if_id_instr_d = rsp_entry.instr;
        end else begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  assign fetch_pc          = fetch_pc_q;
  assign if_id_valid       = if_id_valid_q;
  assign if_id_pc          = if_id_pc_q;
  assign if_id_instruction = if_id_instr_q;

  a_rsp_without_request: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> !pcq_empty);
  a_inflight_tracks_outstanding: assert property (@(posedge clk) disable iff (!reset)
    pcq_count == outstanding_q);
  a_no_inflight_overflow: assert property (@(posedge clk) disable iff (!reset)
    req_fire |-> !pcq_full);
  a_no_queue_overflow: assert property (@(posedge clk) disable iff (!reset)
    (q_push && !q_pop) |-> !q_full);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: in-order imem model plus a
// program-order reference of which PCs may appear in IF/ID.
module tb_if_fetch_stage;
  import riscv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_pc;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;

  if_fetch_stage #(.XLEN(64), .RESET_PC(64'h0), .FQ_DEPTH(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req_valid    (imem_req_valid),
    .imem_req_addr     (imem_req_addr),
    .imem_req_ready    (imem_req_ready),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .fetch_pc          (fetch_pc),
    .if_id_valid       (if_id_valid),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid  = 0;
  int          rsp_pct  = 100;
  logic [63:0] pend [$];
  logic [63:0] exp_pc;
  logic        m_valid;
  logic [63:0] m_pc;
  logic        s_fire, s_redirect, s_stall;
  logic [63:0] s_addr, s_rpc;

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshake before the edge, then update imem and reference after it.
  task automatic tick();
    @(negedge clk);
    s_fire     = imem_req_valid && imem_req_ready;
    s_addr     = imem_req_addr;
    s_redirect = redirect_valid;
    s_rpc      = redirect_pc;
    s_stall    = stall;
    @(posedge clk);
    #1;
    if (s_fire) pend.push_back(s_addr);
    if (pend.size() > 0 && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    if (s_redirect) begin
      check("flush_valid", if_id_valid, 0);
      check("flush_nop", if_id_instruction, NOP_INSTR);
      exp_pc  = s_rpc;
      m_valid = 1'b0;
    end else if (s_stall) begin
      check("stall_valid", if_id_valid, m_valid);
      if (m_valid) begin
        check("stall_pc", if_id_pc, m_pc);
        check("stall_instr", if_id_instruction, instr_of(m_pc));
      end else begin
        check("stall_nop", if_id_instruction, NOP_INSTR);
      end
    end else if (if_id_valid === 1'b1) begin
      check("seq_pc", if_id_pc, exp_pc);
      check("seq_instr", if_id_instruction, instr_of(exp_pc));
      m_valid = 1'b1;
      m_pc    = exp_pc;
      exp_pc  = exp_pc + 64'd4;
      n_valid++;
    end else begin
      check("bubble_nop", if_id_instruction, NOP_INSTR);
      m_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(input string tag);
    int guard = 0;
    while (if_id_valid !== 1'b1 && guard < 12) begin
      tick();
      guard++;
    end
    check(tag, if_id_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int start_valid;
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_pc         = 64'h0;
    m_valid        = 1'b0;
    m_pc           = '0;

    // Reset state
    #12;
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_valid", if_id_valid, 0);
    check("rst_pc", if_id_pc, 0);
    check("rst_instr", if_id_instruction, NOP_INSTR);
    check("rst_req_valid", imem_req_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Latency and streaming
    tick();
    check("lat_bubble", if_id_valid, 0);
    tick();
    check("lat_first", if_id_valid, 1);
    check("lat_pc", if_id_pc, 64'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stream_valid", if_id_valid, 1);
    end
    check("stream_pc8", if_id_pc, 64'h8);

    // Stall for 3 cycles: queue fills, requests stop
    stall = 1'b1;
    tick();
    tick();
    check("stall_req_drop", imem_req_valid, 0);
    tick();
    check("stall_hold_8", if_id_pc, 64'h8);
    stall = 1'b0;
    tick();
    check("unstall_v0", if_id_valid, 1);
    check("unstall_c", if_id_pc, 64'hC);
    tick();
    check("unstall_v1", if_id_valid, 1);
    check("unstall_10", if_id_pc, 64'h10);
    tick();
    check("unstall_v2", if_id_valid, 1);

    // Redirect with two requests outstanding
    rsp_pct = 0;
    for (int i = 0; i < 8 && pend.size() < 2; i++) tick();
    check("two_outstanding", pend.size(), 2);
    rsp_pct        = 100;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    #1;
    check("redir_req_valid", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    wait_valid("redir_arrive");
    check("redir_target", if_id_pc, 64'h100);
    tick();
    tick();

    // Redirect and stall together: flush wins
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick();
    check("rs_valid", if_id_valid, 0);
    check("rs_nop", if_id_instruction, NOP_INSTR);
    stall          = 1'b0;
    redirect_valid = 1'b0;

    // Backpressure: address held at 0xC
    redirect_valid = 1'b1;
    redirect_pc    = 64'hC;
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_addr", imem_req_addr, 64'hC);
      check("bp_fetch_pc", fetch_pc, 64'hC);
    end
    check("bp_req_valid", imem_req_valid, 1);
    imem_req_ready = 1'b1;
    wait_valid("bp_resume");
    check("bp_first_c", if_id_pc, 64'hC);
    tick();
    check("bp_next_valid", if_id_valid, 1);
    check("bp_next_10", if_id_pc, 64'h10);

    // PC wrap-around at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    start_valid = n_valid;
    for (int i = 0; i < 12 && (n_valid - start_valid) < 3; i++) tick();
    check("wrap_count", n_valid - start_valid, 3);
    check("wrap_zero", if_id_pc, 64'h0);

    // Asynchronous reset mid-stream at PC 0x40
    redirect_valid = 1'b1;
    redirect_pc    = 64'h30;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !(if_id_valid === 1'b1 && if_id_pc == 64'h40); i++) tick();
    check("reach_40", if_id_pc, 64'h40);
    reset = 1'b0;
    #1;
    check("mid_rst_fetch_pc", fetch_pc, 0);
    check("mid_rst_valid", if_id_valid, 0);
    check("mid_rst_pc", if_id_pc, 0);
    check("mid_rst_instr", if_id_instruction, NOP_INSTR);
    check("mid_rst_req", imem_req_valid, 0);
    pend.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    exp_pc         = 64'h0;
    m_valid        = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    check("restart_bubble", if_id_valid, 0);
    tick();
    check("restart_valid", if_id_valid, 1);
    check("restart_pc", if_id_pc, 64'h0);

    // Randomized traffic against the program-order reference
    rsp_pct     = 60;
    start_valid = n_valid;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(99) < 75);
      stall          = ($urandom_range(99) < 25);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = {$urandom, $urandom} & ~64'h3;
      tick();
    end
    check("random_progress", (n_valid - start_valid) > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
